// File: rtl/riscv_pipe_pkg.sv
// Shared encodings and per-stage control-word layouts for the RV32I pipeline.
package riscv_pipe_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_e_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Combinational hazard detection: load-use stall, redirect flush, operand forwarding.
module hazard_unit
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs1_d_i,
    input  logic [REG_AW-1:0] rs2_d_i,
    input  logic [REG_AW-1:0] rs1_e_i,
    input  logic [REG_AW-1:0] rs2_e_i,
    input  logic [REG_AW-1:0] rd_e_i,
    input  logic [1:0]        result_src_e_i,
    input  logic              pc_src_e_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_w_i,
    input  logic [REG_AW-1:0] rd_w_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic [1:0]        forward_a_e_o,
    output logic [1:0]        forward_b_e_o
);

    logic lw_stall;

    // Memory stage is younger than writeback, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (reg_write_m_i && (rd_m_i != '0) && (rs == rd_m_i))
            return FWD_MEM;
        else if (reg_write_w_i && (rd_w_i != '0) && (rs == rd_w_i))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign lw_stall = (result_src_e_i == RES_MEM) && (rd_e_i != '0) &&
                      ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));

    // A redirect squashes the dependent instruction anyway, so it overrides the stall.
    assign stall_f_o     = lw_stall & ~pc_src_e_i;
    assign stall_d_o     = lw_stall & ~pc_src_e_i;
    assign flush_d_o     = pc_src_e_i;
    assign flush_e_o     = lw_stall | pc_src_e_i;
    assign forward_a_e_o = fwd_sel(rs1_e_i);
    assign forward_b_e_o = fwd_sel(rs2_e_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Control pipeline registers D->E->M->W, branch/jump redirect and hazard controls.
module pipeline_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [1:0]        ResultSrcD,
    input  logic [2:0]        ALUControlD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              ZeroE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic              PCSrcE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [REG_AW-1:0] RdW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE
);

    ctrl_e_t           ctrl_e_d, ctrl_e_q;
    ctrl_m_t           ctrl_m_d, ctrl_m_q;
    ctrl_w_t           ctrl_w_d, ctrl_w_q;
    logic [REG_AW-1:0] rs1_e_d, rs1_e_q, rs2_e_d, rs2_e_q, rd_e_d, rd_e_q;
    logic [REG_AW-1:0] rd_m_q, rd_w_q;

    always_comb begin
        ctrl_e_d = '{reg_write:   RegWriteD,
                     result_src:  ResultSrcD,
                     mem_write:   MemWriteD,
                     jump:        JumpD,
                     branch:      BranchD,
                     alu_control: ALUControlD,
                     alu_src:     ALUSrcD};
        rs1_e_d  = Rs1D;
        rs2_e_d  = Rs2D;
        rd_e_d   = RdD;
        // Bubble: an all-zero word has no architectural side effects.
        if (FlushE) begin
            ctrl_e_d = '0;
            rs1_e_d  = '0;
            rs2_e_d  = '0;
            rd_e_d   = '0;
        end
    end

    assign ctrl_m_d = '{reg_write:  ctrl_e_q.reg_write,
                        result_src: ctrl_e_q.result_src,
                        mem_write:  ctrl_e_q.mem_write};
    assign ctrl_w_d = '{reg_write:  ctrl_m_q.reg_write,
                        result_src: ctrl_m_q.result_src};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e_q <= '0;
            rs1_e_q  <= '0;
            rs2_e_q  <= '0;
            rd_e_q   <= '0;
            ctrl_m_q <= '0;
            rd_m_q   <= '0;
            ctrl_w_q <= '0;
            rd_w_q   <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            rs1_e_q  <= rs1_e_d;
            rs2_e_q  <= rs2_e_d;
            rd_e_q   <= rd_e_d;
            ctrl_m_q <= ctrl_m_d;
            rd_m_q   <= rd_e_q;
            ctrl_w_q <= ctrl_w_d;
            rd_w_q   <= rd_m_q;
        end
    end

    assign PCSrcE = (ctrl_e_q.branch & ZeroE) | ctrl_e_q.jump;

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .rs1_d_i        (Rs1D),
        .rs2_d_i        (Rs2D),
        .rs1_e_i        (rs1_e_q),
        .rs2_e_i        (rs2_e_q),
        .rd_e_i         (rd_e_q),
        .result_src_e_i (ctrl_e_q.result_src),
        .pc_src_e_i     (PCSrcE),
        .reg_write_m_i  (ctrl_m_q.reg_write),
        .rd_m_i         (rd_m_q),
        .reg_write_w_i  (ctrl_w_q.reg_write),
        .rd_w_i         (rd_w_q),
        .stall_f_o      (StallF),
        .stall_d_o      (StallD),
        .flush_d_o      (FlushD),
        .flush_e_o      (FlushE),
        .forward_a_e_o  (ForwardAE),
        .forward_b_e_o  (ForwardBE)
    );

    assign RegWriteE   = ctrl_e_q.reg_write;
    assign MemWriteE   = ctrl_e_q.mem_write;
    assign ALUSrcE     = ctrl_e_q.alu_src;
    assign ResultSrcE  = ctrl_e_q.result_src;
    assign ALUControlE = ctrl_e_q.alu_control;
    assign RegWriteM   = ctrl_m_q.reg_write;
    assign MemWriteM   = ctrl_m_q.mem_write;
    assign ResultSrcM  = ctrl_m_q.result_src;
    assign RegWriteW   = ctrl_w_q.reg_write;
    assign ResultSrcW  = ctrl_w_q.result_src;
    assign RdW         = rd_w_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboarded directed test of pipeline_ctrl: driver queues cycle-tagged expectations, monitor checks at negedge.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0] ResultSrcD;
    logic [2:0] ALUControlD;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       ZeroE;
    logic       RegWriteE, MemWriteE, ALUSrcE, PCSrcE, RegWriteM, MemWriteM, RegWriteW;
    logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW, ForwardAE, ForwardBE;
    logic [2:0] ALUControlE;
    logic [4:0] RdW;
    logic       StallF, StallD, FlushD, FlushE;

    pipeline_ctrl #(.REG_AW(5)) dut (
        .clk(clk), .reset(reset),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rwe, mwe, ase;
        logic [1:0] rse;
        logic [2:0] alue;
        logic       pcs, rwm, mwm;
        logic [1:0] rsm;
        logic       rww;
        logic [1:0] rsw;
        logic [4:0] rdw;
        logic       stf, std, fld, fle;
        logic [1:0] fae, fbe;
    } obs_t;

    typedef struct {
        string nm;
        int    cyc;
        obs_t  m;
        obs_t  v;
    } chk_t;

    obs_t obs, m, v;
    chk_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    assign obs = {RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE, PCSrcE,
                  RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW, RdW,
                  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation tagged for this cycle is checked on the falling edge.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                checks++;
                if ((obs & q[i].m) !== q[i].v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h mask=%h",
                             q[i].nm, cyc, obs & q[i].m, q[i].v, q[i].m);
                end
                q.delete(i);
            end
        end
    end

    task automatic clr();
        m = '0;
        v = '0;
    endtask

    task automatic ex(input string nm, input int c);
        chk_t e;
        e.nm  = nm;
        e.cyc = c;
        e.m   = m;
        e.v   = v & m;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic rw, input logic mw, input logic j, input logic b,
                       input logic as, input logic [1:0] rs, input logic [2:0] alu,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        RegWriteD = rw; MemWriteD = mw; JumpD = j; BranchD = b; ALUSrcD = as;
        ResultSrcD = rs; ALUControlD = alu; Rs1D = r1; Rs2D = r2; RdD = rd;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            nop();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1;
        ZeroE = 1'b0;
        nop();
        tick();
        clr(); m = '1; ex("reset_state", cyc);
        tick();
        reset = 1'b0;

        // Latency: one word through E, M, W
        c = cyc;
        drv(1, 0, 0, 0, 1, 2'b10, 3'b101, 5'd0, 5'd0, 5'd7);
        clr(); m.rwe = '1; m.ase = '1; m.rse = '1; m.alue = '1;
        v.rwe = 1; v.ase = 1; v.rse = 2'b10; v.alue = 3'b101; ex("lat_E", c + 1);
        clr(); m.rwm = '1; m.rsm = '1; v.rwm = 1; v.rsm = 2'b10; ex("lat_M", c + 2);
        clr(); m.rww = '1; m.rsw = '1; m.rdw = '1;
        v.rww = 1; v.rsw = 2'b10; v.rdw = 5'd7; ex("lat_W", c + 3);
        nops(4);

        // Load-use: one bubble, then WB forward
        tick(); c = cyc;
        drv(1, 0, 0, 0, 1, 2'b01, 3'b000, 5'd1, 5'd0, 5'd5);
        tick();
        drv(1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd5, 5'd6, 5'd8);
        clr(); m.stf = '1; m.std = '1; m.fle = '1; m.fld = '1;
        v.stf = 1; v.std = 1; v.fle = 1; ex("ld_stall", c + 1);
        tick();
        clr(); m.rwe = '1; m.rse = '1; m.stf = '1; m.fle = '1; m.fae = '1;
        ex("ld_bubble", c + 2);
        tick(); nop();
        clr(); m.fae = '1; m.fbe = '1; m.rwe = '1; m.rwm = '1; m.rww = '1; m.rdw = '1; m.stf = '1;
        v.fae = 2'b01; v.rwe = 1; v.rww = 1; v.rdw = 5'd5; ex("ld_fwd", c + 3);
        nops(4);

        // Forwarding priority: M over W, then a WB-only and M-only split
        tick(); c = cyc;
        drv(1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd3);
        tick();
        drv(1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd3);
        tick();
        drv(1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd3, 5'd3, 5'd9);
        clr(); m.stf = '1; m.fle = '1; ex("fwd_nostall", c + 2);
        tick();
        drv(0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd3, 5'd9, 5'd0);
        clr(); m.fae = '1; m.fbe = '1; m.rdw = '1; v.fae = 2'b10; v.fbe = 2'b10; v.rdw = 5'd3;
        ex("fwd_prio", c + 3);
        tick(); nop();
        clr(); m.fae = '1; m.fbe = '1; v.fae = 2'b01; v.fbe = 2'b10; ex("fwd_split", c + 4);
        nops(4);

        // Taken branch
        tick(); c = cyc;
        drv(0, 0, 0, 1, 0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        ZeroE = 1'b1;
        drv(1, 1, 0, 0, 0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd10);
        clr(); m.pcs = '1; m.fld = '1; m.fle = '1; m.stf = '1; m.std = '1;
        v.pcs = 1; v.fld = 1; v.fle = 1; ex("br_taken", c + 1);
        tick();
        ZeroE = 1'b0; nop();
        clr(); m.rwe = '1; m.mwe = '1; m.pcs = '1; m.fld = '1; m.fle = '1;
        ex("br_flushed_E", c + 2);
        clr(); m.rwm = '1; m.mwm = '1; ex("br_flushed_M", c + 3);
        nops(3);

        // Not-taken branch
        tick(); c = cyc;
        drv(0, 0, 0, 1, 0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        ZeroE = 1'b0;
        drv(1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd11);
        clr(); m.pcs = '1; m.fld = '1; m.fle = '1; ex("br_not_taken", c + 1);
        clr(); m.rwe = '1; v.rwe = 1; ex("br_nt_passes", c + 2);
        nops(2);

        // Jump redirects with ZeroE low
        tick(); c = cyc;
        drv(1, 0, 1, 0, 0, 2'b10, 3'b000, 5'd0, 5'd0, 5'd1);
        tick(); nop();
        clr(); m.pcs = '1; m.fld = '1; m.fle = '1; m.rwe = '1;
        v.pcs = 1; v.fld = 1; v.fle = 1; v.rwe = 1; ex("jump", c + 1);
        tick();
        clr(); m.pcs = '1; m.rwe = '1; m.rwm = '1; v.rwm = 1; ex("jump_after", c + 2);
        nops(3);

        // x0 guard
        tick(); c = cyc;
        drv(1, 0, 0, 0, 0, 2'b01, 3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        drv(1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd12);
        clr(); m.stf = '1; m.std = '1; m.fle = '1; ex("x0_nostall", c + 1);
        tick(); nop();
        clr(); m.rwm = '1; m.rwe = '1; m.fae = '1; m.fbe = '1; v.rwm = 1; v.rwe = 1;
        ex("x0_nofwd", c + 2);
        nops(4);

        // Asynchronous reset mid-stream, then clean restart
        tick(); c = cyc;
        drv(1, 0, 0, 0, 0, 2'b10, 3'b000, 5'd0, 5'd0, 5'd13);
        tick();
        clr(); m.rwe = '1; v.rwe = 1; ex("pre_reset", c + 1);
        tick();
        clr(); m = '1; ex("async_reset", c + 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drv(1, 0, 0, 0, 0, 2'b10, 3'b011, 5'd0, 5'd0, 5'd14);
        clr(); m.rww = '1; m.rwe = '1; ex("reset_held", c + 3);
        clr(); m.rwe = '1; m.alue = '1; v.rwe = 1; v.alue = 3'b011; ex("restart_E", c + 4);
        clr(); m.rww = '1; m.rdw = '1; ex("restart_W_early", c + 5);
        clr(); m.rww = '1; m.rsw = '1; m.rdw = '1; v.rww = 1; v.rsw = 2'b10; v.rdw = 5'd14;
        ex("restart_W", c + 6);
        nops(6);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
